// File: rtl/tlb_pkg.sv
// Shared TLB types: entry layout, segment codes and the CP0 EntryLo packer.
package tlb_pkg;

    localparam logic [2:0] KSEG0  = 3'b100;
    localparam logic [2:0] KSEG1  = 3'b101;
    localparam logic [2:0] CACHED = 3'b011;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    function automatic logic [31:0] lo_word(
        input logic [19:0] pfn,
        input logic [2:0]  c,
        input logic        d,
        input logic        v,
        input logic        g
    );
        return {6'b0, pfn, c, d, v, g};
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative VPN2/ASID compare with lowest-index priority.
module tlb_match #(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0][18:0] i_vpn2s,
    input  logic [TLBNUM-1:0][7:0]  i_asids,
    input  logic [TLBNUM-1:0]       i_gs,
    input  logic [18:0]             i_vpn2,
    input  logic [7:0]              i_asid,
    output logic                    o_hit,
    output logic [IDXW-1:0]         o_index
);

    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        // Scan downwards so the lowest matching index wins.
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (i_vpn2s[i] == i_vpn2 &&
                (i_asids[i] == i_asid || i_gs[i])) begin
                o_hit   = 1'b1;
                o_index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_mp.sv
// Multi-port MIPS-style TLB with tlbp/tlbr/tlbwi/tlbwr and Wired/Random.
module tlb_mp
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    parameter  int NSRCH  = 2,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [2:0]            k0,
    input  logic [7:0]            asid,
    input  logic [NSRCH-1:0]      s_req,
    input  logic [32*NSRCH-1:0]   s_vaddr,
    input  logic [NSRCH-1:0]      s_store,
    output logic [NSRCH-1:0]      s_ack,
    output logic [20*NSRCH-1:0]   s_ptag,
    output logic [NSRCH-1:0]      s_uncached,
    output logic [NSRCH-1:0]      s_refill,
    output logic [NSRCH-1:0]      s_invalid,
    output logic [NSRCH-1:0]      s_modify,
    input  logic [31:0]           cp0_hi,
    input  logic [31:0]           cp0_lo0,
    input  logic [31:0]           cp0_lo1,
    input  logic [31:0]           cp0_index,
    input  logic                  op_tlbp,
    input  logic                  op_tlbr,
    input  logic                  op_tlbwi,
    input  logic                  op_tlbwr,
    input  logic                  wired_we,
    input  logic [IDXW-1:0]       wired_wdata,
    output logic [IDXW-1:0]       wired,
    output logic [IDXW-1:0]       random,
    output logic                  p_done,
    output logic [31:0]           p_index,
    output logic                  r_done,
    output logic [31:0]           r_hi,
    output logic [31:0]           r_lo0,
    output logic [31:0]           r_lo1
);

    tlb_entry_t [TLBNUM-1:0]  r_tlb;
    logic [IDXW-1:0]          r_wired;
    logic [IDXW-1:0]          r_random;
    logic [NSRCH-1:0]         r_ack, r_unc, r_refill, r_invalid, r_modify;
    logic [20*NSRCH-1:0]      r_ptag;
    logic                     r_p_done, r_r_done;
    logic [31:0]              r_p_index, r_hi_q, r_lo0_q, r_lo1_q;

    logic [TLBNUM-1:0][18:0]  w_vpn2s;
    logic [TLBNUM-1:0][7:0]   w_asids;
    logic [TLBNUM-1:0]        w_gs;
    logic [NSRCH-1:0]         w_unc_n, w_refill_n, w_invalid_n, w_modify_n;
    logic [20*NSRCH-1:0]      w_ptag_n;
    logic [NSRCH-1:0]         w_unused_va;
    logic                     w_p_hit;
    logic [IDXW-1:0]          w_p_idx;
    logic                     w_we;
    logic [IDXW-1:0]          w_widx;
    logic [IDXW-1:0]          w_ridx;
    tlb_entry_t               w_new;
    tlb_entry_t               w_rd;
    logic                     w_unused;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            w_vpn2s[i] = r_tlb[i].vpn2;
            w_asids[i] = r_tlb[i].asid;
            w_gs[i]    = r_tlb[i].g;
        end
    end

    for (genvar p = 0; p < NSRCH; p++) begin : g_port
        logic [31:0]     w_va;
        logic            w_hit;
        logic [IDXW-1:0] w_idx;
        logic            w_odd, w_unm;
        logic [19:0]     w_pfn;
        logic [2:0]      w_c;
        logic            w_d, w_v;

        assign w_va = s_vaddr[32*p +: 32];

        tlb_match #(.TLBNUM(TLBNUM)) u_match (
            .i_vpn2s (w_vpn2s),
            .i_asids (w_asids),
            .i_gs    (w_gs),
            .i_vpn2  (w_va[31:13]),
            .i_asid  (asid),
            .o_hit   (w_hit),
            .o_index (w_idx)
        );

        assign w_odd = w_va[12];
        assign w_pfn = w_odd ? r_tlb[w_idx].pfn1 : r_tlb[w_idx].pfn0;
        assign w_c   = w_odd ? r_tlb[w_idx].c1   : r_tlb[w_idx].c0;
        assign w_d   = w_odd ? r_tlb[w_idx].d1   : r_tlb[w_idx].d0;
        assign w_v   = w_odd ? r_tlb[w_idx].v1   : r_tlb[w_idx].v0;
        assign w_unm = (w_va[31:29] == KSEG0) || (w_va[31:29] == KSEG1);

        assign w_ptag_n[20*p +: 20] = w_unm ? {3'b0, w_va[28:12]} : w_pfn;
        // kseg1 is always uncached; kseg0 follows Config.K0.
        assign w_unc_n[p]     = w_unm ? ((w_va[31:29] == KSEG1) || (k0 != CACHED))
                                      : (w_c != CACHED);
        assign w_refill_n[p]  = s_req[p] & ~w_unm & ~w_hit;
        assign w_invalid_n[p] = s_req[p] & ~w_unm & w_hit & ~w_v;
        assign w_modify_n[p]  = s_req[p] & ~w_unm & s_store[p] & w_hit & w_v & ~w_d;
        assign w_unused_va[p] = ^w_va[11:0];
    end

    tlb_match #(.TLBNUM(TLBNUM)) u_probe (
        .i_vpn2s (w_vpn2s),
        .i_asids (w_asids),
        .i_gs    (w_gs),
        .i_vpn2  (cp0_hi[31:13]),
        .i_asid  (cp0_hi[7:0]),
        .o_hit   (w_p_hit),
        .o_index (w_p_idx)
    );

    assign w_we   = op_tlbwi | op_tlbwr;
    assign w_widx = op_tlbwi ? cp0_index[IDXW-1:0] : r_random;
    assign w_ridx = cp0_index[IDXW-1:0];
    assign w_rd   = r_tlb[w_ridx];

    always_comb begin
        w_new.vpn2 = cp0_hi[31:13];
        w_new.asid = cp0_hi[7:0];
        w_new.g    = cp0_lo0[0] & cp0_lo1[0];
        w_new.pfn0 = cp0_lo0[25:6];
        w_new.c0   = cp0_lo0[5:3];
        w_new.d0   = cp0_lo0[2];
        w_new.v0   = cp0_lo0[1];
        w_new.pfn1 = cp0_lo1[25:6];
        w_new.c1   = cp0_lo1[5:3];
        w_new.d1   = cp0_lo1[2];
        w_new.v1   = cp0_lo1[1];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tlb     <= '0;
            r_wired   <= '0;
            r_random  <= IDXW'(TLBNUM - 1);
            r_ack     <= '0;
            r_ptag    <= '0;
            r_unc     <= '0;
            r_refill  <= '0;
            r_invalid <= '0;
            r_modify  <= '0;
            r_p_done  <= 1'b0;
            r_p_index <= '0;
            r_r_done  <= 1'b0;
            r_hi_q    <= '0;
            r_lo0_q   <= '0;
            r_lo1_q   <= '0;
        end else begin
            r_ack     <= s_req;
            r_ptag    <= w_ptag_n;
            r_unc     <= w_unc_n;
            r_refill  <= w_refill_n;
            r_invalid <= w_invalid_n;
            r_modify  <= w_modify_n;
            if (w_we) r_tlb[w_widx] <= w_new;
            // Random wraps at Wired; a Wired write restarts it from the top.
            if (wired_we) begin
                r_wired  <= wired_wdata;
                r_random <= IDXW'(TLBNUM - 1);
            end else if (r_random == r_wired) begin
                r_random <= IDXW'(TLBNUM - 1);
            end else begin
                r_random <= r_random - IDXW'(1);
            end
            r_p_done <= op_tlbp;
            if (op_tlbp)
                r_p_index <= w_p_hit ? {{(32-IDXW){1'b0}}, w_p_idx}
                                     : 32'h8000_0000;
            r_r_done <= op_tlbr;
            if (op_tlbr) begin
                r_hi_q  <= {w_rd.vpn2, 5'b0, w_rd.asid};
                r_lo0_q <= lo_word(w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g);
                r_lo1_q <= lo_word(w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g);
            end
        end
    end

    assign s_ack      = r_ack;
    assign s_ptag     = r_ptag;
    assign s_uncached = r_unc;
    assign s_refill   = r_refill;
    assign s_invalid  = r_invalid;
    assign s_modify   = r_modify;
    assign wired      = r_wired;
    assign random     = r_random;
    assign p_done     = r_p_done;
    assign p_index    = r_p_index;
    assign r_done     = r_r_done;
    assign r_hi       = r_hi_q;
    assign r_lo0      = r_lo0_q;
    assign r_lo1      = r_lo1_q;

    assign w_unused = ^{cp0_hi[12:8], cp0_lo0[31:26], cp0_lo1[31:26],
                        cp0_index[31:IDXW], w_unused_va};

endmodule

// File: tb/tb_tlb_mp.sv
// Directed bench for tlb_mp: translation, exceptions, tlbp/tlbr, Wired/Random.
module tb_tlb_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  k0;
    logic [7:0]  asid;
    logic [1:0]  s_req, s_store;
    logic [63:0] s_vaddr;
    logic [1:0]  s_ack, s_uncached, s_refill, s_invalid, s_modify;
    logic [39:0] s_ptag;
    logic [31:0] cp0_hi, cp0_lo0, cp0_lo1, cp0_index;
    logic        op_tlbp, op_tlbr, op_tlbwi, op_tlbwr;
    logic        wired_we;
    logic [3:0]  wired_wdata, wired, random;
    logic        p_done, r_done;
    logic [31:0] p_index, r_hi, r_lo0, r_lo1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_mp #(.TLBNUM(16), .NSRCH(2)) dut (
        .clk(clk), .resetn(resetn), .k0(k0), .asid(asid),
        .s_req(s_req), .s_vaddr(s_vaddr), .s_store(s_store),
        .s_ack(s_ack), .s_ptag(s_ptag), .s_uncached(s_uncached),
        .s_refill(s_refill), .s_invalid(s_invalid), .s_modify(s_modify),
        .cp0_hi(cp0_hi), .cp0_lo0(cp0_lo0), .cp0_lo1(cp0_lo1),
        .cp0_index(cp0_index),
        .op_tlbp(op_tlbp), .op_tlbr(op_tlbr),
        .op_tlbwi(op_tlbwi), .op_tlbwr(op_tlbwr),
        .wired_we(wired_we), .wired_wdata(wired_wdata),
        .wired(wired), .random(random),
        .p_done(p_done), .p_index(p_index),
        .r_done(r_done), .r_hi(r_hi), .r_lo0(r_lo0), .r_lo1(r_lo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 0; k0 = 0; asid = 0;
        s_req = 0; s_store = 0; s_vaddr = 0;
        cp0_hi = 0; cp0_lo0 = 0; cp0_lo1 = 0; cp0_index = 0;
        op_tlbp = 0; op_tlbr = 0; op_tlbwi = 0; op_tlbwr = 0;
        wired_we = 0; wired_wdata = 0;
        tick; tick;
        chk("rst_ack", s_ack, 0);
        chk("rst_random", random, 15);
        chk("rst_wired", wired, 0);
        chk("rst_pdone", p_done, 0);
        chk("rst_rdone", r_done, 0);
        chk("rst_exc", {s_refill, s_invalid, s_modify}, 0);
        resetn = 1;

        // Cleared entry 0 hits vaddr 0 / asid 0 but is not valid
        s_req = 2'b01; s_vaddr = 64'h0; asid = 0;
        tick;
        chk("r21_ack", s_ack, 2'b01);
        chk("r21_invalid", s_invalid, 2'b01);
        chk("r21_refill", s_refill, 2'b00);
        s_req = 0;
        tick;
        chk("r21_ack_drop", s_ack, 0);
        chk("r21_inv_drop", s_invalid, 0);

        // Entry 3: vpn2 0x201 asid 5, odd page PFN 0x12345 C=3 D V
        cp0_index = 3; cp0_hi = 32'h0040_2005;
        cp0_lo0 = 0; cp0_lo1 = 32'h0048_D15E; op_tlbwi = 1;
        tick;
        op_tlbwi = 0;
        s_req = 2'b10; s_store = 2'b10; asid = 5;
        s_vaddr = {32'h0040_3ABC, 32'h0};
        tick;
        chk("r22_ack", s_ack, 2'b10);
        chk("r22_ptag", s_ptag[39:20], 32'h12345);
        chk("r22_unc", s_uncached[1], 0);
        chk("r22_exc", {s_refill[1], s_invalid[1], s_modify[1]}, 0);
        asid = 6;
        tick;
        chk("r22_refill", s_refill[1], 1);
        s_req = 0; s_store = 0;

        // Entry 5: even page valid, not dirty, C=2 -> modify on store
        cp0_index = 5; cp0_hi = 32'h0060_0007;
        cp0_lo0 = 32'h0002_AF12; cp0_lo1 = 0; op_tlbwi = 1;
        tick;
        op_tlbwi = 0;
        s_req = 2'b01; s_store = 2'b01; asid = 7;
        s_vaddr = {32'h0, 32'h0060_0000};
        tick;
        chk("mod_store", s_modify[0], 1);
        chk("mod_unc", s_uncached[0], 1);
        chk("mod_ptag", s_ptag[19:0], 32'h00ABC);
        s_store = 0;
        tick;
        chk("mod_load", s_modify[0], 0);

        // Write and lookup in the same cycle: old contents are seen
        cp0_index = 6; cp0_hi = 32'h0080_0009;
        cp0_lo0 = 32'h0001_DDDE; cp0_lo1 = 0; op_tlbwi = 1;
        s_req = 2'b01; asid = 9; s_vaddr = {32'h0, 32'h0080_0000};
        tick;
        chk("r24_old", s_refill[0], 1);
        op_tlbwi = 0;
        tick;
        chk("r24_new_refill", s_refill[0], 0);
        chk("r24_new_ptag", s_ptag[19:0], 32'h00777);
        chk("r24_new_unc", s_uncached[0], 0);
        s_req = 0;

        // Entries 7 and 2 share one hi; tlbp reports the lower one
        cp0_hi = 32'h0100_0011; cp0_lo0 = 0; cp0_lo1 = 0;
        cp0_index = 7; op_tlbwi = 1;
        tick;
        cp0_index = 2;
        tick;
        op_tlbwi = 0;
        op_tlbp = 1;
        tick;
        chk("r25_done", p_done, 1);
        chk("r25_hit", p_index, 32'h2);
        cp0_hi = 32'h0200_0011;
        tick;
        chk("r25_done2", p_done, 1);
        chk("r25_miss", p_index, 32'h8000_0000);
        op_tlbp = 0;
        tick;
        chk("r25_pulse", p_done, 0);

        // tlbr of entry 3
        cp0_index = 3; op_tlbr = 1;
        tick;
        op_tlbr = 0;
        chk("rd_done", r_done, 1);
        chk("rd_hi", r_hi, 32'h0040_2005);
        chk("rd_lo0", r_lo0, 32'h0);
        chk("rd_lo1", r_lo1, 32'h0048_D15E);
        tick;
        chk("rd_pulse", r_done, 0);

        // Unmapped segments
        s_req = 2'b01; s_store = 2'b01; k0 = 0; asid = 0;
        s_vaddr = {32'h0, 32'hBFC0_0000};
        tick;
        chk("k1_ptag", s_ptag[19:0], 32'h1FC00);
        chk("k1_unc", s_uncached[0], 1);
        chk("k1_exc", {s_refill[0], s_invalid[0], s_modify[0]}, 0);
        s_vaddr = {32'h0, 32'h8000_1000}; k0 = 3;
        tick;
        chk("k0_ptag", s_ptag[19:0], 32'h00001);
        chk("k0_cached", s_uncached[0], 0);
        k0 = 2;
        tick;
        chk("k0_uncached", s_uncached[0], 1);
        s_req = 0; s_store = 0;

        // Wired = 4, then Random walks 14..4 and wraps
        wired_we = 1; wired_wdata = 4;
        tick;
        wired_we = 0;
        chk("wired_set", wired, 4);
        chk("random_top", random, 15);
        for (int v = 14; v >= 4; v--) begin
            tick;
            chk("random_dec", random, v);
        end
        cp0_hi = 32'h0200_0033; cp0_lo0 = 32'h3; cp0_lo1 = 32'h1;
        cp0_index = 9; op_tlbwr = 1;
        tick;
        op_tlbwr = 0;
        chk("random_wrap", random, 15);
        cp0_index = 4; op_tlbr = 1;
        tick;
        op_tlbr = 0;
        chk("wr_hi", r_hi, 32'h0200_0033);
        chk("wr_lo0", r_lo0, 32'h3);
        chk("wr_lo1", r_lo1, 32'h1);

        // tlbwr with wired_we uses pre-update random (14)
        wired_we = 1; wired_wdata = 2; op_tlbwr = 1;
        cp0_hi = 32'h0300_0044; cp0_lo0 = 0; cp0_lo1 = 0;
        tick;
        wired_we = 0; op_tlbwr = 0;
        chk("wr_wired2", wired, 2);
        chk("wr_random2", random, 15);
        cp0_index = 14; op_tlbr = 1;
        tick;
        op_tlbr = 0;
        chk("wr_old_rand", r_hi, 32'h0300_0044);

        // tlbwi wins over tlbwr
        op_tlbwi = 1; op_tlbwr = 1; cp0_index = 1;
        cp0_hi = 32'h0400_0055;
        tick;
        op_tlbwi = 0; op_tlbwr = 0; op_tlbr = 1;
        tick;
        op_tlbr = 0;
        chk("wi_prio", r_hi, 32'h0400_0055);

        // Reset dominates everything in flight
        resetn = 0; op_tlbp = 1; op_tlbr = 1; op_tlbwi = 1;
        s_req = 2'b11; cp0_index = 3;
        tick;
        chk("r18_ack", s_ack, 0);
        chk("r18_pdone", p_done, 0);
        chk("r18_rdone", r_done, 0);
        chk("r18_random", random, 15);
        chk("r18_wired", wired, 0);
        resetn = 1; op_tlbp = 0; op_tlbwi = 0; s_req = 0;
        tick;
        op_tlbr = 0;
        chk("r18_clear_hi", r_hi, 0);
        chk("r18_clear_lo1", r_lo1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
